uart_rx_shift: RTL and testbench
================================

# uart_rx_shift

UART receiver for the iCE40 tester, the receive-side counterpart of the shift-register UART transmitter driving `ftdi_tx`. It samples the FTDI serial line `ftdi_rx` at mid-bit and deserialises 8N1 frames, LSB first. Each completed byte is presented on a valid/ready holding register for consumption by `top`-level logic. Framing and overrun errors are reported as single-cycle pulses.

## Interface
- `CLKS_PER_BIT`, default 104: `hwclk` cycles per bit (12 MHz / 115200). Legal range 4..65535.
- `CNT_W`, default 16: width of the bit-timing counter; must hold `CLKS_PER_BIT-1`.
- `hwclk` in 1: system clock, 12 MHz; all logic on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `ftdi_rx` in 1: asynchronous serial input, idle high.
- `rx_ready` in 1: consumer accepts `rx_data` when high with `rx_valid`.
- `rx_data` out 8: received byte; stable while `rx_valid` is high.
- `rx_valid` out 1: byte available; held until accepted.
- `frame_err` out 1: one-cycle pulse, bad stop bit (or parity, see Configuration).
- `overrun` out 1: one-cycle pulse, byte dropped because buffer full.
- `busy` out 1: high in any state other than IDLE.

## Operation
- `ftdi_rx` passes through a 2-flop synchroniser (reset to 1), then a 1-flop edge register. `rx_s` is the synchronised value.
- States: IDLE, START, DATA, STOP (and PARITY when enabled).
- IDLE: on `rx_s` falling edge go to START, clear counter.
- START: count to `CLKS_PER_BIT/2 - 1` (integer division). If `rx_s` is low then, go to DATA with the counter cleared; otherwise this is a glitch: back to IDLE, no error.
- DATA: count to `CLKS_PER_BIT-1`, sample `rx_s` into the shift register MSB and shift right; after 8 samples go to STOP.
- STOP: count to `CLKS_PER_BIT-1`, sample. If high, the byte is good; if low, pulse `frame_err` and discard the byte. Return to IDLE immediately after the sample. Do not wait for end of stop bit; this permits back-to-back frames.
- Holding buffer:
  - A good byte loads `rx_data` and sets `rx_valid`.
  - Handshake completes when `rx_valid && rx_ready`; `rx_valid` clears the next cycle.
  - If a good byte completes while `rx_valid` is high and `rx_ready` is low, pulse `overrun`. The new byte is dropped and the old byte is kept.
  - If a good byte completes in the same cycle as acceptance, load the new byte and keep `rx_valid` high. No overrun.
- Reset values: `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0, state IDLE, shift register 0.
- Reset mid-frame aborts the frame; no partial byte is ever presented.
- A line held low (break) produces a frame with `frame_err`. IDLE then waits for a new falling edge, so no spurious re-trigger while the line stays low.

## Timing
- Let t be the cycle in which the falling edge is detected on `rx_s`, 3 cycles after the pin edge.
- Start-bit check at t + `CLKS_PER_BIT/2`.
- Data bit i (0..7) sampled at t + `CLKS_PER_BIT/2` + (i+1)·`CLKS_PER_BIT`.
- Stop bit sampled at t + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT`.
- `rx_valid` rises, or `frame_err` pulses, one cycle after the stop sample.
- `busy` rises at t+1 and falls with the return to IDLE.
- `rx_ready` has no combinational path to any output.

## Configuration
- `UART_RX_PARITY_EN` defined: an even-parity bit is expected between bit 7 and stop, handled by the PARITY state with the same `CLKS_PER_BIT` timing.
  - On a parity mismatch, `frame_err` pulses at the stop sample and the byte is discarded.
  - Stop sample moves to t + `CLKS_PER_BIT/2` + 10·`CLKS_PER_BIT`.
- `UART_RX_PARITY_EN` undefined: 8N1 exactly as above; no parity logic is synthesised.

## Test plan
- Use `CLKS_PER_BIT`=8. Send 0xA5 (8N1), `rx_ready`=1 → `rx_valid` high 1 cycle, `rx_data`=0xA5, `frame_err`=0, `busy` low afterwards.
- Send 0x3C with `rx_ready`=0, then 0x81 → `rx_data` stays 0x3C, `overrun` pulses once at the second frame. Then raise `rx_ready` → `rx_valid` clears, `rx_data`=0x3C.
- Send 0x55 with stop bit forced low → `frame_err` pulses one cycle, `rx_valid` stays 0. Next frame 0x0F decodes correctly.
- Send a 3-cycle low glitch on an idle line → no `rx_valid`, no `frame_err`; `busy` returns to 0 within `CLKS_PER_BIT/2`+2 cycles.
- Drop `rx_n` during bit 4 of 0xFF, then send 0x12 → all outputs at reset values during reset; only 0x12 is delivered.
- With `UART_RX_PARITY_EN` defined: send 0x07 with parity 1 → accepted. Send 0x07 with parity 0 → `frame_err`, no `rx_valid`.

Source files
------------

// File: rtl/uart_rx_shift.sv
// 8N1 UART receiver: mid-bit sampling, LSB-first deserialiser, valid/ready holding register.
// Define UART_RX_PARITY_EN to expect an even-parity bit between bit 7 and the stop bit.
module uart_rx_shift #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       hwclk,
    input  logic       rst_n,
    input  logic       ftdi_rx,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state;
    logic             sync1;
    logic             rx_s;
    logic             rx_d;
    logic             fall;
    logic             bit_end;
    logic             stop_ok;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    assign fall    = rx_d & ~rx_s;
    assign bit_end = (cnt == BIT_LAST);
    assign busy    = (state != IDLE);

    // Synchroniser and edge register idle high so reset release never looks like a start bit.
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            sync1 <= ftdi_rx;
            rx_s  <= sync1;
            rx_d  <= rx_s;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_err;

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            par_err <= 1'b0;
        end else if (state == PARITY && bit_end) begin
            par_err <= ^{shift, rx_s};
        end
    end

    assign stop_ok = rx_s & ~par_err;
`else
    assign stop_ok = rx_s;
`endif

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (fall) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        shift   <= {rx_s, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= IDLE;
                        // A load here overrides the accept-clear above, so accept+load keeps rx_valid high.
                        if (!stop_ok) begin
                            frame_err <= 1'b1;
                        end else if (rx_valid && !rx_ready) begin
                            overrun <= 1'b1;
                        end else begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_shift.sv
// Bench for uart_rx_shift at CLKS_PER_BIT=8: directed vector table, timing/corner sequences, random frames.
// Parity cases are built when UART_RX_PARITY_EN is defined.
module tb_uart_rx_shift;

    localparam int unsigned CPB = 8;
    localparam int unsigned H   = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif
    // Posedge (counted from the start-bit drive) at which the stop bit is sampled.
    localparam int unsigned STOP_EDGE = 3 + H + (NBITS - 1) * CPB;

    logic       hwclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ftdi_rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx_shift #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
        .hwclk    (hwclk),
        .rst_n    (rst_n),
        .ftdi_rx  (ftdi_rx),
        .rx_ready (rx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 hwclk = ~hwclk;

    int         checks = 0;
    int         errors = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt = 0;
    logic [7:0] acc_q[$];

    always @(negedge hwclk) begin
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (rx_valid && rx_ready) acc_q.push_back(rx_data);
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic cyc(input int unsigned n);
        repeat (n) @(posedge hwclk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par);
        logic [10:0] frame;
`ifdef UART_RX_PARITY_EN
        frame = {stop_bit, par, d, 1'b0};
`else
        frame = {par, stop_bit, d, 1'b0};
`endif
        for (int unsigned i = 0; i < NBITS; i++) begin
            ftdi_rx = frame[i];
            cyc(CPB);
        end
        ftdi_rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       ready;
        int         exp_acc;
        logic [7:0] exp_last;
        logic       exp_valid;
        logic [7:0] exp_data;
        int         exp_ferr;
        int         exp_ovr;
    } vec_t;

    vec_t vecs[5];

    task automatic apply_vec(input int idx);
        int a0, f0, o0;
        vec_t v;
        v  = vecs[idx];
        a0 = acc_q.size();
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        rx_ready = v.ready;
        send_frame(v.data, v.stop, ^v.data);
        cyc(4);
        check($sformatf("vec%0d accepted", idx), acc_q.size() - a0, v.exp_acc);
        if (v.exp_acc > 0 && acc_q.size() > 0)
            check($sformatf("vec%0d last_byte", idx), acc_q[$], v.exp_last);
        check($sformatf("vec%0d rx_valid", idx), rx_valid, v.exp_valid);
        check($sformatf("vec%0d rx_data", idx), rx_data, v.exp_data);
        check($sformatf("vec%0d frame_err", idx), ferr_cnt - f0, v.exp_ferr);
        check($sformatf("vec%0d overrun", idx), ovr_cnt - o0, v.exp_ovr);
        check($sformatf("vec%0d busy", idx), busy, 1'b0);
    endtask

    initial begin
        int a0, f0;
        logic [7:0] exp_q[$];
        int exp_ferr;
        logic prev_bad;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1, 8'hA5, 1'b0, 8'hA5, 0, 0};
        vecs[1] = '{8'h3C, 1'b1, 1'b0, 0, 8'h00, 1'b1, 8'h3C, 0, 0};
        vecs[2] = '{8'h81, 1'b1, 1'b0, 0, 8'h00, 1'b1, 8'h3C, 0, 1};
        vecs[3] = '{8'h55, 1'b0, 1'b0, 0, 8'h00, 1'b1, 8'h3C, 1, 0};
        vecs[4] = '{8'h0F, 1'b1, 1'b1, 1, 8'h0F, 1'b0, 8'h0F, 0, 0};

        cyc(3);
        check("reset rx_data", rx_data, 8'h00);
        check("reset rx_valid", rx_valid, 1'b0);
        check("reset frame_err", frame_err, 1'b0);
        check("reset overrun", overrun, 1'b0);
        check("reset busy", busy, 1'b0);
        rst_n = 1'b1;
        cyc(4);

        for (int i = 0; i < 4; i++) apply_vec(i);

        a0 = acc_q.size();
        rx_ready = 1'b1;
        cyc(2);
        check("release accepted", acc_q.size() - a0, 1);
        if (acc_q.size() > 0) check("release byte", acc_q[$], 8'h3C);
        check("release rx_valid", rx_valid, 1'b0);
        check("release rx_data", rx_data, 8'h3C);

        apply_vec(4);

        // Exact latency of busy and rx_valid relative to the start-bit drive.
        rx_ready = 1'b1;
        fork
            send_frame(8'h5A, 1'b1, 1'b0);
            begin
                repeat (2) @(posedge hwclk);
                @(negedge hwclk) check("busy before t+1", busy, 1'b0);
                @(posedge hwclk);
                @(negedge hwclk) check("busy at t+1", busy, 1'b1);
                repeat (STOP_EDGE - 4) @(posedge hwclk);
                @(negedge hwclk) check("valid before stop", rx_valid, 1'b0);
                @(posedge hwclk);
                @(negedge hwclk) check("valid after stop", rx_valid, 1'b1);
                check("timed rx_data", rx_data, 8'h5A);
                check("busy after stop", busy, 1'b0);
            end
        join
        cyc(4);

        a0 = acc_q.size();
        f0 = ferr_cnt;
        ftdi_rx = 1'b0;
        cyc(3);
        ftdi_rx = 1'b1;
        cyc(H + 2);
        check("glitch busy", busy, 1'b0);
        check("glitch accepted", acc_q.size() - a0, 0);
        check("glitch frame_err", ferr_cnt - f0, 0);
        cyc(CPB * 12);
        check("glitch late accepted", acc_q.size() - a0, 0);

        a0 = acc_q.size();
        f0 = ferr_cnt;
        fork
            send_frame(8'hFF, 1'b1, 1'b0);
            begin
                cyc(CPB * 5 + 3);
                rst_n = 1'b0;
                cyc(1);
                check("midrst rx_data", rx_data, 8'h00);
                check("midrst rx_valid", rx_valid, 1'b0);
                check("midrst frame_err", frame_err, 1'b0);
                check("midrst overrun", overrun, 1'b0);
                check("midrst busy", busy, 1'b0);
                cyc(2);
                rst_n = 1'b1;
            end
        join
        cyc(4);
        send_frame(8'h12, 1'b1, 1'b0);
        cyc(4);
        check("post-reset accepted", acc_q.size() - a0, 1);
        if (acc_q.size() > 0) check("post-reset byte", acc_q[$], 8'h12);
        check("post-reset frame_err", ferr_cnt - f0, 0);

        a0 = acc_q.size();
        f0 = ferr_cnt;
        ftdi_rx = 1'b0;
        cyc(CPB * 25);
        check("break frame_err", ferr_cnt - f0, 1);
        check("break accepted", acc_q.size() - a0, 0);
        check("break busy while low", busy, 1'b0);
        ftdi_rx = 1'b1;
        cyc(CPB * 2);
        check("break after release", ferr_cnt - f0, 1);

`ifdef UART_RX_PARITY_EN
        a0 = acc_q.size();
        f0 = ferr_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        cyc(4);
        check("parity good accepted", acc_q.size() - a0, 1);
        if (acc_q.size() > 0) check("parity good byte", acc_q[$], 8'h07);
        check("parity good frame_err", ferr_cnt - f0, 0);
        a0 = acc_q.size();
        send_frame(8'h07, 1'b1, 1'b0);
        cyc(4);
        check("parity bad accepted", acc_q.size() - a0, 0);
        check("parity bad frame_err", ferr_cnt - f0, 1);
        check("parity bad rx_valid", rx_valid, 1'b0);
`endif

        // Random frames: good bytes must arrive in order, every bad frame gives one frame_err.
        rx_ready = 1'b1;
        a0 = acc_q.size();
        f0 = ferr_cnt;
        exp_ferr = 0;
        prev_bad = 1'b0;
        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            logic good, stop_bit, par;
            d = 8'($urandom);
            good = ($urandom_range(0, 3) != 0);
            stop_bit = 1'b1;
            par = ^d;
            if (!good) begin
`ifdef UART_RX_PARITY_EN
                if ($urandom_range(0, 1) == 1) par = ~par;
                else stop_bit = 1'b0;
`else
                stop_bit = 1'b0;
`endif
            end
            ftdi_rx = 1'b1;
            cyc($urandom_range(prev_bad ? 1 : 0, 12));
            send_frame(d, stop_bit, par);
            prev_bad = !stop_bit;
            if (good) exp_q.push_back(d);
            else exp_ferr++;
        end
        cyc(CPB * 2);
        check("random count", acc_q.size() - a0, exp_q.size());
        check("random frame_err", ferr_cnt - f0, exp_ferr);
        for (int i = 0; i < exp_q.size() && a0 + i < acc_q.size(); i++)
            check($sformatf("random byte %0d", i), acc_q[a0 + i], exp_q[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
